// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, word type and the memory arbiter's
// state and operation encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        HIT   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_FETCH = 2'd2
    } arb_op_t;

    // Load value returned when an access ends in ERROR or times out.
    localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/access_timer.sv
// Saturating wait counter for one RAM access. Held at zero while clear is high,
// counts cycles while enable is high, and flags the last allowed cycle.
module access_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    localparam int W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] TC_VAL  = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority, otherwise increment without wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data read/write.
// Data requests win over fetches. Every access is bounded by a timeout, and
// completion is reported through a one-cycle HIT state so a request dropped
// on the hit edge is never sampled again.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES = 16,
    parameter word_t ERR_WORD       = ERR_WORD_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        err
);

    arb_state_t state_q, state_d;
    arb_op_t    op_q, op_d;
    word_t      addr_q, addr_d;
    word_t      store_q, store_d;
    word_t      iload_q, iload_d;
    word_t      dload_q, dload_d;
    logic       err_q, err_d;

    logic in_access;
    logic timeout;

    assign in_access = (state_q == DATA) || (state_q == INSTR);

    access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (nRST),
        .clear  (!in_access),
        .enable (in_access),
        .tc     (timeout)
    );

    // Next state, request latching and load/err capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        store_d = store_q;
        iload_d = iload_q;
        dload_d = dload_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    op_d    = dWEN ? OP_WRITE : OP_READ;
                    addr_d  = daddr;
                    store_d = dstore;
                    state_d = DATA;
                end else if (iREN) begin
                    op_d    = OP_FETCH;
                    addr_d  = iaddr;
                    state_d = INSTR;
                end
            end
            DATA, INSTR: begin
                if (ramstate == ACCESS) begin
                    if (op_q == OP_READ) begin
                        dload_d = ramload;
                    end else if (op_q == OP_FETCH) begin
                        iload_d = ramload;
                    end
                    state_d = HIT;
                end else if ((ramstate == ERROR) || timeout) begin
                    // A failed write has nothing to return, so dload keeps its value.
                    if (op_q == OP_READ) begin
                        dload_d = ERR_WORD;
                    end else if (op_q == OP_FETCH) begin
                        iload_d = ERR_WORD;
                    end
                    err_d   = 1'b1;
                    state_d = HIT;
                end
            end
            HIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            store_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            err_q   <= err_d;
        end
    end

    // RAM and hit outputs decoded from the current state and latched op.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        case (state_q)
            DATA: begin
                ramaddr = addr_q;
                if (op_q == OP_WRITE) begin
                    ramWEN   = 1'b1;
                    ramstore = store_q;
                end else begin
                    ramREN = 1'b1;
                end
            end
            INSTR: begin
                ramaddr = addr_q;
                ramREN  = 1'b1;
            end
            HIT: begin
                ihit = (op_q == OP_FETCH);
                dhit = (op_q != OP_FETCH);
            end
            default: begin
            end
        endcase
    end

    assign iload = iload_q;
    assign dload = dload_q;
    assign err   = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter. The bench plays both the
// request unit and the RAM; expectations come from the arbitration rules.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int    T   = 4;
    localparam word_t ERW = 32'hBAD1BAD1;

    logic        CLK;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    ramstate_t   ramstate;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the arbiter should be holding.
    word_t m_iload = '0;
    word_t m_dload = '0;
    logic  m_err   = 1'b0;

    memory_arbiter #(.TIMEOUT_CYCLES(T), .ERR_WORD(ERW)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
        .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ihit(ihit), .dhit(dhit),
        .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
        .ramstate(ramstate), .err(err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request from the request unit: optional data op plus optional fetch,
    // each served by the RAM after nbusy BUSY cycles and then resp.
    task automatic run_txn(input string tag, input logic dr, input logic dw, input logic ir,
                           input word_t da, input word_t ds, input word_t ia,
                           input int nbusy, input ramstate_t resp, input word_t rl);
        bit    is_data[$];
        int    w, k, en_exp;
        bit    good, d, wr;
        word_t ld;
        if (dr || dw) is_data.push_back(1'b1);
        if (ir) is_data.push_back(1'b0);
        dREN = dr; dWEN = dw; iREN = ir;
        daddr = da; dstore = ds; iaddr = ia;
        good   = (resp == ACCESS) && (nbusy <= T - 1);
        en_exp = ((nbusy < T - 1) ? nbusy : T - 1) + 1;
        for (int a = 0; a < is_data.size(); a++) begin
            d  = is_data[a];
            wr = d && dw;
            ld = d ? rl : ~rl;
            w = 0;
            do begin
                @(negedge CLK);
                w++;
                if (!(ramREN || ramWEN)) chk({tag, "_idle_nohit"}, {30'd0, ihit, dhit}, 32'd0);
            end while (!(ramREN || ramWEN) && w < 8);
            chk({tag, "_gap"}, w, (a == 0) ? 1 : 2);
            k = 0;
            while ((ramREN || ramWEN) && k < 20) begin
                chk({tag, "_addr"}, ramaddr, d ? da : ia);
                chk({tag, "_en"}, {30'd0, ramREN, ramWEN}, wr ? 32'd1 : 32'd2);
                chk({tag, "_store"}, ramstore, wr ? ds : 32'd0);
                ramstate = (k < nbusy) ? BUSY : resp;
                ramload  = (k < nbusy) ? $urandom : ld;
                k++;
                @(negedge CLK);
            end
            ramstate = FREE;
            ramload  = $urandom;
            chk({tag, "_cycles"}, k, en_exp);
            chk({tag, "_hit"}, {30'd0, ihit, dhit}, d ? 32'd1 : 32'd2);
            if (d) begin
                dREN = 1'b0; dWEN = 1'b0;
                if (!wr) m_dload = good ? ld : ERW;
            end else begin
                iREN = 1'b0;
                m_iload = good ? ld : ERW;
            end
            if (!good) m_err = 1'b1;
            chk({tag, "_dload"}, dload, m_dload);
            chk({tag, "_iload"}, iload, m_iload);
            chk({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
        end
        @(negedge CLK);
        chk({tag, "_after"}, {28'd0, ihit, dhit, ramREN, ramWEN}, 32'd0);
    endtask

    initial begin
        int    kind, nb;
        word_t a1, a2, v;
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (3) @(negedge CLK);
        chk("rst_outs", {26'd0, ihit, dhit, ramREN, ramWEN, err, 1'b0}, 32'd0);
        chk("rst_addr", ramaddr | ramstore | iload | dload, 32'd0);
        nRST = 1'b1;

        // Reset while a fetch is waiting on BUSY.
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge CLK);
        chk("mid_en", {31'd0, ramREN}, 32'd1);
        ramstate = BUSY;
        #2 nRST = 1'b0;
        #1 chk("mid_rst", {29'd0, ihit, ramREN, ramWEN}, 32'd0);
        chk("mid_rst_addr", ramaddr, 32'd0);
        @(negedge CLK);
        iREN = 1'b0; ramstate = FREE; nRST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("mid_after", {29'd0, ihit, dhit, ramREN}, 32'd0);
        end

        run_txn("fetch", 1'b0, 1'b0, 1'b1, '0, '0, 32'h100, 2, ACCESS, 32'h2108000A);
        run_txn("prio", 1'b1, 1'b0, 1'b1, 32'h200, '0, 32'h104, 1, ACCESS, 32'h12345678);
        run_txn("write", 1'b1, 1'b1, 1'b0, 32'h3FC, 32'hDEADBEEF, '0, 0, ACCESS, 32'h55AA55AA);
        chk("err_clear", {31'd0, err}, 32'd0);
        run_txn("tmo", 1'b1, 1'b0, 1'b0, 32'h80, '0, '0, 10, ACCESS, 32'h0BADF00D);
        run_txn("good", 1'b1, 1'b0, 1'b0, 32'h84, '0, '0, 1, ACCESS, 32'hCAFEF00D);
        run_txn("ramerr", 1'b0, 1'b0, 1'b1, '0, '0, 32'h108, 0, ERROR, 32'h11111111);
        run_txn("edge_tc", 1'b0, 1'b0, 1'b1, '0, '0, 32'h10C, T - 1, ACCESS, 32'h77777777);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            nb   = $urandom_range(0, T + 1);
            a1   = $urandom; a2 = $urandom; v = $urandom;
            case (kind)
                0: run_txn("rnd_rd", 1'b1, 1'b0, 1'b0, a1, v, a2, nb, ($urandom_range(0, 5) == 0) ? ERROR : ACCESS, $urandom);
                1: run_txn("rnd_wr", $urandom_range(0, 1) == 1, 1'b1, 1'b0, a1, v, a2, nb, ACCESS, $urandom);
                2: run_txn("rnd_if", 1'b0, 1'b0, 1'b1, a1, v, a2, nb, ACCESS, $urandom);
                3: run_txn("rnd_both", 1'b1, 1'b0, 1'b1, a1, v, a2, nb, ACCESS, $urandom);
                default: run_txn("rnd_wif", 1'b0, 1'b1, 1'b1, a1, v, a2, nb, ($urandom_range(0, 3) == 0) ? ERROR : ACCESS, $urandom);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the request unit and the datapath fetch path.
- Arbitrates instruction-fetch and data read/write requests onto the single-ported RAM, with data taking priority.
- Runs a registered FSM, bounds every RAM access with a timeout, and returns one-cycle ihit/dhit pulses with registered load data.
- The request unit drops its data request on the dhit edge; the arbiter's post-hit cycle guarantees that dropped request is never re-issued.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in an access state before forced completion; must be >= 1.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an access that ends in ERROR or timeout.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request (driven from imemREN)
- iaddr  in  32  instruction word address
- dREN  in  1  data read request (driven from dmemREN)
- dWEN  in  1  data write request (driven from dmemWEN)
- daddr  in  32  data address
- dstore  in  32  data write value
- ihit  out  1  one-cycle pulse: instruction access complete, iload valid
- dhit  out  1  one-cycle pulse: data access complete, dload valid
- iload  out  32  fetched instruction, held until the next instruction completion
- dload  out  32  loaded data, held until the next data completion
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramstate is ACCESS
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- err  out  1  sticky flag: set by any ERROR or timeout completion, cleared only by reset

Behaviour:
- Reset (async, nRST low):
  - state is IDLE.
  - All outputs, latched address/data/op registers and the wait counter are 0.
  - An access in flight is abandoned with no hit pulse.
- States: IDLE, DATA, INSTR, HIT.
- IDLE:
  - ihit, dhit, ramREN, ramWEN are 0; ramaddr and ramstore are 0.
  - If dREN or dWEN is high: latch daddr, dstore and the op; go to DATA. dWEN wins if both dREN and dWEN are high, so the op is a write.
  - Else if iREN is high: latch iaddr; go to INSTR.
  - Else stay in IDLE.
  - When a data and an instruction request arrive in the same cycle, data is always taken first.
- DATA / INSTR:
  - ramaddr = latched address; ramstore = latched dstore (DATA write only, else 0).
  - ramREN = 1 for DATA read and for INSTR; ramWEN = 1 for DATA write only.
  - All outputs are decoded from state plus latched registers, so they are valid in the first cycle of the state.
  - The wait counter clears on entry and increments every cycle spent in the state.
  - ramstate ACCESS: capture ramload into dload (DATA read) or iload (INSTR). A DATA write leaves dload unchanged. Go to HIT.
  - ramstate ERROR, or counter reaching TIMEOUT_CYCLES-1 without ACCESS: load ERR_WORD into the relevant load register (DATA write leaves dload unchanged), set err, go to HIT.
  - Deassertion of the input request mid-access is ignored; the access always completes.
- HIT:
  - Lasts exactly one cycle; then go to IDLE.
  - dhit = 1 if the completed access was DATA, ihit = 1 if it was INSTR; never both.
  - RAM enables are 0; requests are not sampled.
- Latency: the hit pulse is visible 2 cycles after the first cycle of ramstate ACCESS, counting the accepting edge (ACCESS sampled at edge N, HIT during cycle N+1).
- Back-to-back requests: minimum of 3 cycles between consecutive RAM enables of distinct accesses (access state, HIT, IDLE).
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

Decomposition:
- cpu_types_pkg:
  - existing ramstate_t and word_t;
  - new arb_state_t enum (IDLE, DATA, INSTR, HIT);
  - new arb_op_t (OP_READ, OP_WRITE, OP_FETCH).
- ERR_WORD default is also declared as a package constant.
- One sub-module, access_timer: clear/enable saturating counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.
- FSM, latches and output decode stay in memory_arbiter.

Test Plan:
- Reset mid-access: enter INSTR, pull nRST low while ramstate is BUSY -> all outputs 0 immediately, no ihit, state IDLE after release.
- Fetch: iREN=1, iaddr=0x100, RAM returns ACCESS after 2 BUSY cycles with ramload=0x2108000A -> ramREN=1 with ramaddr=0x100 for 3 cycles, then ihit=1 for 1 cycle, iload=0x2108000A.
- Priority: iREN=1 and dREN=1 in the same cycle, daddr=0x200 -> first RAM access uses ramaddr=0x200 with dhit; next access uses ramaddr=iaddr; dREN dropped on dhit causes no second data access.
- Write: dWEN=1 and dREN=1, daddr=0x3FC, dstore=0xDEADBEEF, immediate ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit pulse, dload unchanged.
- Timeout: TIMEOUT_CYCLES=4, ramstate held BUSY on a data read -> enables high for exactly 4 cycles, dhit pulse, dload=0xBAD1BAD1, err=1 and stays 1 after later good accesses.
- ERROR response: fetch with ramstate=ERROR in its first cycle -> ihit the following cycle, iload=0xBAD1BAD1, err=1.
